// File: rtl/tff_bank_pkg.sv
// Shared mode encoding for the toggle-register bank and its users.
package tff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_UP      = 2'b01,
    MODE_DOWN    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  // True for the two binary counting modes, where only T[0] is meaningful.
  function automatic logic is_count_mode(input mode_e m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop: XOR of toggle and state feeding a D flop, with
// synchronous active-high reset and a parallel load that overrides the enable.
module tff_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic E,
  input  logic LD,
  input  logic D,
  input  logic T,
  output logic Q
);

  logic q_d;
  logic q_q;

  // NOTE: q_d gets its hold value first so no path through the if-chain leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = D;
    end else if (E) begin
      q_d = q_q ^ T;
    end
  end

  // NOTE: flops use non-blocking assignment so every cell samples pre-edge values.
  always_ff @(posedge C) begin
    if (R) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/tff_bank_counter.sv
// Bank of WIDTH T flip-flops used as raw toggle register or binary up/down
// counter, with load, optional saturation, terminal-count, wrap and error flags.
module tff_bank_counter
  import tff_bank_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             ERR
);

  mode_e            mode;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;
  logic [WIDTH-1:0] tgl;
  logic             at_max;
  logic             at_min;
  logic             at_end;
  logic             wrap_d;
  logic             wrap_q;
  logic             err_d;
  logic             err_q;

  assign mode   = mode_e'(MODE);
  assign at_max = &Q;
  assign at_min = ~|Q;

  // Bit i toggles when all lower bits are ones (carry) or all zeros (borrow).
  always_comb begin : chains
    logic acc_up;
    logic acc_dn;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_chain[i] = acc_up;
      dn_chain[i] = acc_dn;
      acc_up      = acc_up & Q[i];
      acc_dn      = acc_dn & ~Q[i];
    end
  end

  // Saturation suppresses the whole toggle vector at the end value, so Q holds.
  always_comb begin
    tgl = '0;
    case (mode)
      MODE_TOGGLE: tgl = T;
      MODE_UP:     if (T[0] && !(SATURATE && at_max)) tgl = up_chain;
      MODE_DOWN:   if (T[0] && !(SATURATE && at_min)) tgl = dn_chain;
      default:     tgl = '0;
    endcase
  end

  assign at_end = is_count_mode(mode) &&
                  (((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_min));
  assign TC     = at_end;

  assign wrap_d = !LD && E && T[0] && at_end && !SATURATE;
  assign err_d  = err_q || (!LD && E && (mode == MODE_ILLEGAL));

  always_ff @(posedge C) begin
    if (R) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign WRAP = wrap_q;
  assign ERR  = err_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell #(
      .RESET_VAL(RESET_VAL[g])
    ) u_cell (
      .C (C),
      .R (R),
      .E (E),
      .LD(LD),
      .D (D[g]),
      .T (tgl[g]),
      .Q (Q[g])
    );
  end

endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter: wrapping, saturating and 1-bit instances share
// stimulus; an arithmetic model is compared every cycle, plus literal checks.
module tb_tff_bank_counter;

  logic       clk;
  logic       r, ld, e;
  logic [1:0] mode;
  logic [3:0] t, d;

  logic [3:0] q0, q1;
  logic [0:0] qw;
  logic       tc0, tc1, tcw;
  logic       wrap0, wrap1, wrapw;
  logic       err0, err1, errw;

  int n_tests = 0;
  int n_fail  = 0;

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) dut_wrap (
    .C(clk), .R(r), .E(e), .LD(ld), .D(d), .MODE(mode), .T(t),
    .Q(q0), .TC(tc0), .WRAP(wrap0), .ERR(err0));

  tff_bank_counter #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) dut_sat (
    .C(clk), .R(r), .E(e), .LD(ld), .D(d), .MODE(mode), .T(t),
    .Q(q1), .TC(tc1), .WRAP(wrap1), .ERR(err1));

  tff_bank_counter #(.WIDTH(1), .RESET_VAL(1'b1), .SATURATE(1'b0)) dut_w1 (
    .C(clk), .R(r), .E(e), .LD(ld), .D(d[0:0]), .MODE(mode), .T(t[0:0]),
    .Q(qw), .TC(tcw), .WRAP(wrapw), .ERR(errw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    bit          wrap;
    bit          err;
  } mst_t;

  mst_t m0, m1, mw;
  bit   mvalid = 1'b0;

  // Register value as a number modulo 2^w, following the priority rules.
  function automatic mst_t model_next(input mst_t s, input int w, input bit sat,
                                      input int unsigned rv, input bit r_i, input bit ld_i,
                                      input bit e_i, input int unsigned md,
                                      input int unsigned tv, input int unsigned dv);
    int unsigned top = (1 << w) - 1;
    mst_t n = s;
    n.wrap = 1'b0;
    if (r_i) begin
      n.q   = rv;
      n.err = 1'b0;
    end else if (ld_i) begin
      n.q = dv & top;
    end else if (e_i) begin
      case (md)
        0: n.q = s.q ^ (tv & top);
        1: if ((tv & 1) != 0) begin
             if (s.q == top) begin
               if (!sat) begin n.q = 0; n.wrap = 1'b1; end
             end else n.q = s.q + 1;
           end
        2: if ((tv & 1) != 0) begin
             if (s.q == 0) begin
               if (!sat) begin n.q = top; n.wrap = 1'b1; end
             end else n.q = s.q - 1;
           end
        default: n.err = 1'b1;
      endcase
    end
    return n;
  endfunction

  function automatic bit model_tc(input int unsigned q, input int w, input int unsigned md);
    int unsigned top = (1 << w) - 1;
    return ((md == 1) && (q == top)) || ((md == 2) && (q == 0));
  endfunction

  always @(posedge clk) begin
    m0 <= model_next(m0, 4, 1'b0, 5, r, ld, e, mode, t, d);
    m1 <= model_next(m1, 4, 1'b1, 5, r, ld, e, mode, t, d);
    mw <= model_next(mw, 1, 1'b0, 1, r, ld, e, mode, t, d);
    if (r) mvalid <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input int q, input bit tc, input bit wr,
                          input bit er, input mst_t m, input int w);
    check({tag, "_q"},    q,  int'(m.q));
    check({tag, "_tc"},   tc, int'(model_tc(m.q, w, mode)));
    check({tag, "_wrap"}, wr, int'(m.wrap));
    check({tag, "_err"},  er, int'(m.err));
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp_inst("wrap4", q0, tc0, wrap0, err0, m0, 4);
      cmp_inst("sat4",  q1, tc1, wrap1, err1, m1, 4);
      cmp_inst("w1",    qw, tcw, wrapw, errw, mw, 1);
    end
  end

  task automatic step(input bit r_i, input bit ld_i, input bit e_i, input logic [1:0] m_i,
                      input logic [3:0] t_i, input logic [3:0] d_i);
    r = r_i; ld = ld_i; e = e_i; mode = m_i; t = t_i; d = d_i;
    @(posedge clk);
    #4;
  endtask

  initial begin
    r = 1'b1; ld = 1'b0; e = 1'b0; mode = 2'b00; t = '0; d = '0;

    // Reset wins over load and count.
    step(1, 1, 1, 2'b01, 4'h1, 4'hA);
    check("rst_q", q0, 5); check("rst_wrap", wrap0, 0); check("rst_err", err0, 0);
    check("rst_w1_q", qw, 1);
    step(0, 1, 0, 2'b00, 4'h0, 4'h9);
    check("ld9_q", q0, 9); check("ld9_w1_q", qw, 1);

    // Raw toggle mode and enable gating.
    step(0, 1, 0, 2'b00, 4'h0, 4'h5);
    step(0, 0, 1, 2'b00, 4'hA, 4'h0);
    check("tgl1_q", q0, 4'hF); check("tgl1_wrap", wrap0, 0);
    step(0, 0, 1, 2'b00, 4'hA, 4'h0);
    check("tgl2_q", q0, 4'h5);
    step(0, 0, 0, 2'b00, 4'hF, 4'h0);
    check("hold_q", q0, 4'h5);

    // Count up through the all-ones end value.
    step(0, 1, 0, 2'b01, 4'h0, 4'hE);
    step(0, 0, 1, 2'b01, 4'h1, 4'h0);
    check("up_f_q", q0, 4'hF); check("up_f_tc", tc0, 1); check("sat_up_f_tc", tc1, 1);
    step(0, 0, 1, 2'b01, 4'h1, 4'h0);
    check("up_wrap_q", q0, 0); check("up_wrap_pulse", wrap0, 1);
    check("sat_up_hold_q", q1, 4'hF); check("sat_up_wrap", wrap1, 0);
    step(0, 0, 1, 2'b01, 4'h1, 4'h0);
    check("up_after_q", q0, 1); check("up_after_wrap", wrap0, 0);

    // Count down through zero.
    step(0, 1, 0, 2'b10, 4'h0, 4'h1);
    step(0, 0, 1, 2'b10, 4'h1, 4'h0);
    check("sat_dn0_q", q1, 0); check("sat_dn0_tc", tc1, 1);
    step(0, 0, 1, 2'b10, 4'h1, 4'h0);
    check("sat_dn_hold_q", q1, 0); check("sat_dn_wrap", wrap1, 0);
    check("dn_wrap_q", q0, 4'hF); check("dn_wrap_pulse", wrap0, 1);
    step(0, 0, 1, 2'b10, 4'h1, 4'h0);
    check("sat_dn_hold2_q", q1, 0); check("dn_after_q", q0, 4'hE);

    // Illegal mode sets sticky error; reset clears it.
    step(0, 0, 1, 2'b11, 4'hF, 4'h0);
    check("ill_q", q0, 4'hE); check("ill_err", err0, 1);
    step(0, 0, 1, 2'b01, 4'h1, 4'h0);
    check("ill_sticky_err", err0, 1); check("ill_resume_q", q0, 4'hF);
    step(1, 0, 1, 2'b01, 4'h1, 4'h0);
    check("ill_rst_err", err0, 0); check("ill_rst_q", q0, 5);

    // Load beats wrap; reset mid-count leaves no wrap.
    step(0, 1, 0, 2'b01, 4'h0, 4'hF);
    step(0, 1, 1, 2'b01, 4'h1, 4'h3);
    check("ldwin_q", q0, 3); check("ldwin_wrap", wrap0, 0);
    step(0, 0, 1, 2'b01, 4'h1, 4'h0);
    check("ldwin_cnt_q", q0, 4);
    step(1, 0, 1, 2'b01, 4'h1, 4'h0);
    check("midrst_q", q0, 5); check("midrst_wrap", wrap0, 0);
    step(0, 0, 0, 2'b01, 4'h1, 4'h0);
    check("midrst_wrap2", wrap0, 0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] mr;
      mr = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), mr, 4'($urandom), 4'($urandom));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
